// File: rtl/frame_rx_parser.sv
// Receive-side frame parser: preamble/SFD strip, CRC-32 and length check,
// FCS-stripped payload stream, per-frame status and saturating counters.
module frame_rx_parser #(
  parameter int PRE_MIN = 7,
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  txd,
  input  logic        tx_en,
  output logic [7:0]  m_data,
  output logic        m_valid,
  output logic        m_sop,
  output logic        frame_done,
  output logic        crc_err,
  output logic        len_err,
  output logic        pre_err,
  output logic [15:0] good_cnt,
  output logic [15:0] bad_cnt
);

  localparam logic [3:0]  PRE_M   = 4'(PRE_MIN);
  localparam logic [15:0] MIN_L   = 16'(MIN_LEN);
  localparam logic [15:0] MAX_L   = 16'(MAX_LEN);
  localparam logic [31:0] RESIDUE = 32'hC704DD7B;

  typedef enum logic [1:0] {IDLE, PRE, DATA, DROP} state_t;

  state_t      state;
  logic [3:0]  pre_cnt;
  logic [15:0] len;
  logic [31:0] crc;
  logic [31:0] crc_rev;
  logic [31:0] pipe;
  logic [2:0]  fill;
  logic        sop_pend;
  logic        e_pre;
  logic        e_len;
  logic        en_q;
  logic        ending;
  logic        f_crc;
  logic        f_len;
  logic        f_pre;

  function automatic logic [31:0] crc_byte(
    input logic [31:0] c,
    input logic [7:0]  d
  );
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  // Residue constant is in normal bit order; register is reflected.
  always_comb begin
    crc_rev = '0;
    for (int i = 0; i < 32; i++)
      crc_rev[i] = crc[31-i];
  end

  always_comb begin
    ending = !tx_en && (state != IDLE);
    f_crc  = (state == DATA) && (crc_rev != RESIDUE);
    f_len  = (state == DATA) ? (len < MIN_L) : e_len;
    f_pre  = (state == PRE) ? 1'b1 : e_pre;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pre_cnt    <= '0;
      len        <= '0;
      crc        <= '1;
      pipe       <= '0;
      fill       <= '0;
      sop_pend   <= 1'b0;
      e_pre      <= 1'b0;
      e_len      <= 1'b0;
      en_q       <= tx_en;
      m_data     <= '0;
      m_valid    <= 1'b0;
      m_sop      <= 1'b0;
      frame_done <= 1'b0;
      crc_err    <= 1'b0;
      len_err    <= 1'b0;
      pre_err    <= 1'b0;
      good_cnt   <= '0;
      bad_cnt    <= '0;
    end else begin
      en_q       <= tx_en;
      m_valid    <= 1'b0;
      m_sop      <= 1'b0;
      frame_done <= 1'b0;
      if (ending) begin
        frame_done <= 1'b1;
        crc_err    <= f_crc;
        len_err    <= f_len;
        pre_err    <= f_pre;
        if (!(f_crc || f_len || f_pre)) begin
          if (good_cnt != 16'hFFFF)
            good_cnt <= good_cnt + 16'd1;
        end else if (bad_cnt != 16'hFFFF) begin
          bad_cnt <= bad_cnt + 16'd1;
        end
        state <= IDLE;
      end else begin
        unique case (state)
          IDLE: begin
            // Only a rising tx_en starts a frame, so a reset
            // mid-frame waits out the remainder.
            if (tx_en && !en_q) begin
              e_len <= 1'b0;
              if (txd == 8'h55) begin
                state   <= PRE;
                pre_cnt <= 4'd1;
                e_pre   <= 1'b0;
              end else begin
                state <= DROP;
                e_pre <= 1'b1;
              end
            end
          end
          PRE: begin
            if (txd == 8'h55) begin
              if (pre_cnt != 4'hF)
                pre_cnt <= pre_cnt + 4'd1;
            end else if (txd == 8'hD5 && pre_cnt >= PRE_M) begin
              state    <= DATA;
              crc      <= '1;
              len      <= '0;
              fill     <= '0;
              sop_pend <= 1'b1;
            end else begin
              state <= DROP;
              e_pre <= 1'b1;
            end
          end
          DATA: begin
            if (len == MAX_L) begin
              state <= DROP;
              e_len <= 1'b1;
            end else begin
              crc  <= crc_byte(crc, txd);
              len  <= len + 16'd1;
              pipe <= {pipe[23:0], txd};
              if (fill == 3'd4) begin
                m_valid  <= 1'b1;
                m_data   <= pipe[31:24];
                m_sop    <= sop_pend;
                sop_pend <= 1'b0;
              end else begin
                fill <= fill + 3'd1;
              end
            end
          end
          DROP: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_frame_rx_parser.sv
// Bench for frame_rx_parser: frame generator with its own FCS, scoreboard
// of expected payload beats and per-frame status.
module tb_frame_rx_parser;

  logic        clk;
  logic        rst;
  logic [7:0]  txd;
  logic        tx_en;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_sop;
  logic        frame_done;
  logic        crc_err;
  logic        len_err;
  logic        pre_err;
  logic [15:0] good_cnt;
  logic [15:0] bad_cnt;

  int errors = 0;
  int checks = 0;
  int fd_cnt = 0;
  int exp_good = 0;
  int exp_bad = 0;
  bit mon_off = 0;
  bit fr_bad = 0;

  logic [7:0] fr[$];
  logic [8:0] exp_q[$];
  logic [2:0] st_q[$];

  frame_rx_parser dut (
    .clk(clk), .rst(rst), .txd(txd), .tx_en(tx_en),
    .m_data(m_data), .m_valid(m_valid), .m_sop(m_sop),
    .frame_done(frame_done), .crc_err(crc_err),
    .len_err(len_err), .pre_err(pre_err),
    .good_cnt(good_cnt), .bad_cnt(bad_cnt)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // One clock; outputs sampled 1ns after the edge and scored.
  task automatic step();
    logic [8:0] e;
    logic [2:0] s;
    @(posedge clk);
    #1;
    if (!rst) begin
      if (frame_done) fd_cnt++;
      if (!mon_off && m_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL beat_extra: got data=%02h sop=%0b, required none",
                   m_data, m_sop);
        end else begin
          e = exp_q.pop_front();
          if ({m_sop, m_data} !== e) begin
            errors++;
            $display("FAIL beat: got sop=%0b data=%02h, required sop=%0b data=%02h",
                     m_sop, m_data, e[8], e[7:0]);
          end
        end
      end
      if (!mon_off && frame_done) begin
        checks++;
        if (st_q.size() == 0) begin
          errors++;
          $display("FAIL status_extra: unexpected frame_done");
        end else begin
          s = st_q.pop_front();
          if ({crc_err, len_err, pre_err} !== s) begin
            errors++;
            $display("FAIL status: got crc/len/pre=%03b, required %03b",
                     {crc_err, len_err, pre_err}, s);
          end
        end
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    tx_en = 1'b1;
    txd = b;
    step();
  endtask

  task automatic build_frame(input int n_data, input bit bad);
    logic [31:0] c;
    logic [31:0] fcs;
    logic [7:0] b;
    bit fb;
    fr.delete();
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < n_data; i++) begin
      b = 8'(i);
      fr.push_back(b);
      for (int j = 0; j < 8; j++) begin
        fb = c[0] ^ b[j];
        c = c >> 1;
        if (fb) c = c ^ 32'hEDB8_8320;
      end
    end
    fcs = ~c;
    if (bad) fcs[0] = ~fcs[0];
    for (int k = 0; k < 4; k++) fr.push_back(fcs[8*k +: 8]);
    fr_bad = bad;
  endtask

  task automatic send_frame(input int npre);
    int n, nf;
    bit pe, le, ce;
    n = fr.size();
    pe = (npre < 7);
    le = !pe && (n < 64 || n > 1518);
    ce = !pe && (n <= 1518) && fr_bad;
    if (!pe) begin
      nf = ((n > 1518) ? 1518 : n) - 4;
      for (int i = 0; i < nf; i++) exp_q.push_back({(i == 0), fr[i]});
    end
    st_q.push_back({ce, le, pe});
    if (pe || le || ce) exp_bad++;
    else exp_good++;
    for (int i = 0; i < npre; i++) send_byte(8'h55);
    send_byte(8'hD5);
    for (int i = 0; i < n; i++) send_byte(fr[i]);
    tx_en = 1'b0;
    txd = 8'h00;
    step();
    checks++;
    if (frame_done !== 1'b1 || m_valid !== 1'b0) begin
      errors++;
      $display("FAIL end_timing: got frame_done=%0b m_valid=%0b, required 1 0",
               frame_done, m_valid);
    end
    checks++;
    if (good_cnt !== 16'(exp_good) || bad_cnt !== 16'(exp_bad)) begin
      errors++;
      $display("FAIL counters: got good=%0d bad=%0d, required good=%0d bad=%0d",
               good_cnt, bad_cnt, exp_good, exp_bad);
    end
    checks++;
    if (exp_q.size() != 0 || st_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d beats %0d status left, required 0 0",
               exp_q.size(), st_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tx_en = 1'b0;
    txd = 8'h00;
    repeat (3) step();
    checks++;
    if ({m_valid, m_sop, frame_done, crc_err, len_err, pre_err} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: got %06b, required 000000",
               {m_valid, m_sop, frame_done, crc_err, len_err, pre_err});
    end
    checks++;
    if (good_cnt !== 16'h0 || bad_cnt !== 16'h0 || m_data !== 8'h0) begin
      errors++;
      $display("FAIL reset_regs: got good=%0d bad=%0d data=%02h, required 0 0 00",
               good_cnt, bad_cnt, m_data);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_good();
    build_frame(60, 0);
    send_frame(7);
  endtask

  task automatic test_crc();
    build_frame(60, 1);
    send_frame(7);
  endtask

  task automatic test_preamble();
    build_frame(60, 0);
    send_frame(5);
  endtask

  task automatic test_length();
    build_frame(36, 0);
    send_frame(7);
    build_frame(1596, 0);
    send_frame(7);
  endtask

  task automatic test_back_to_back();
    build_frame(60, 0);
    send_frame(7);
    build_frame(60, 0);
    send_frame(8);
  endtask

  task automatic test_mid_reset();
    int fd0;
    build_frame(60, 0);
    mon_off = 1;
    fd0 = fd_cnt;
    for (int i = 0; i < 7; i++) send_byte(8'h55);
    send_byte(8'hD5);
    for (int i = 0; i < fr.size(); i++) begin
      if (i == 20) rst = 1'b1;
      if (i == 22) rst = 1'b0;
      send_byte(fr[i]);
    end
    tx_en = 1'b0;
    txd = 8'h00;
    repeat (3) step();
    checks++;
    if (fd_cnt != fd0) begin
      errors++;
      $display("FAIL mid_reset_done: got %0d frame_done, required 0", fd_cnt - fd0);
    end
    checks++;
    if (good_cnt !== 16'h0 || bad_cnt !== 16'h0) begin
      errors++;
      $display("FAIL mid_reset_cnt: got good=%0d bad=%0d, required 0 0",
               good_cnt, bad_cnt);
    end
    exp_q.delete();
    st_q.delete();
    exp_good = 0;
    exp_bad = 0;
    mon_off = 0;
    build_frame(60, 0);
    send_frame(7);
  endtask

  initial begin
    rst = 1'b1;
    tx_en = 1'b0;
    txd = 8'h00;
    test_reset();
    test_good();
    test_crc();
    test_preamble();
    test_length();
    test_back_to_back();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
